cond_logic: RTL and testbench

//   ARM condition unit downstream of the ALU. Holds the NZCV status register,

---
 rtl/arm_pkg.sv | 33 +++
 rtl/cond_logic_if.sv | 32 +++
 rtl/cond_check.sv | 42 ++++
 rtl/cond_logic.sv | 55 +++++
 tb/tb_cond_logic.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared ARM condition-unit definitions: condition codes, NZCV bit
// positions and the status-register type.
package arm_pkg;

    // Instr[31:28] condition field encodings.
    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // Bit positions inside an NZCV word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-facing bundle of the condition unit.
// There is no valid/ready handshake on this bundle: every input is sampled
// each cycle and every output is a same-cycle combinational function of the
// inputs and the stored flags.
interface cond_logic_if;
    import arm_pkg::*;

    logic [3:0] Cond;
    nzcv_t      ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    nzcv_t      Flags;

    // Decoder/datapath side: drives the instruction controls.
    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    // Condition unit side.
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

endinterface

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: Cond field vs an NZCV snapshot.
// Kept stateless so the same block can be dropped into a trace checker.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  nzcv_t      Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition field against the flag snapshot; NV never passes.
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ:      CondEx = z;
            NE:      CondEx = ~z;
            CS:      CondEx = c;
            CC:      CondEx = ~c;
            MI:      CondEx = n;
            PL:      CondEx = ~n;
            VS:      CondEx = v;
            VC:      CondEx = ~v;
            HI:      CondEx = c & ~z;
            LS:      CondEx = ~c | z;
            GE:      CondEx = (n == v);
            LT:      CondEx = (n != v);
            GT:      CondEx = ~z & (n == v);
            LE:      CondEx = z | (n != v);
            AL:      CondEx = 1'b1;
            NV:      CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// ARM condition unit: holds NZCV, evaluates each instruction's condition
// against the pre-update flags and gates the decoder's write enables.
module cond_logic
    import arm_pkg::*;
#(
    parameter nzcv_t RESET_FLAGS = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    nzcv_t      flags;
    logic       cond_ex;

    // Flags seen by the condition check are the registered ones only;
    // ALUFlags never bypasses into the current cycle's decision.
    assign flags = {nz_q, cv_q};

    cond_check u_cond_check (
        .Cond   (bus.Cond),
        .Flags  (flags),
        .CondEx (cond_ex)
    );

    // N,Z register: loaded only by a passing instruction that writes N,Z.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q <= RESET_FLAGS[3:2];
        end else if (bus.FlagW[1] && cond_ex) begin
            nz_q <= bus.ALUFlags[3:2];
        end
    end

    // C,V register: independent enable so logical ops can leave C,V alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_q <= RESET_FLAGS[1:0];
        end else if (bus.FlagW[0] && cond_ex) begin
            cv_q <= bus.ALUFlags[1:0];
        end
    end

    // A failed condition squashes every architectural side effect.
    always_comb begin
        bus.PCSrc    = bus.PCS  & cond_ex;
        bus.RegWrite = bus.RegW & cond_ex;
        bus.MemWrite = bus.MemW & cond_ex;
        bus.CondEx   = cond_ex;
        bus.Flags    = flags;
    end

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for the ARM condition unit with an NZCV reference model.
module tb_cond_logic;

    localparam logic [3:0] RESET_FLAGS = 4'b0000;

    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CC = 4'h3, C_HI = 4'h8;
    localparam logic [3:0] C_GE = 4'hA, C_LT = 4'hB, C_GT = 4'hC, C_LE = 4'hD;
    localparam logic [3:0] C_AL = 4'hE, C_NV = 4'hF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    cond_logic_if bus ();

    cond_logic #(.RESET_FLAGS(RESET_FLAGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    // ---------------- reference model ----------------
    logic [3:0] m_flags = RESET_FLAGS;

    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, signed_ge;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        signed_ge = (n == v);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !(cy && !z);
            4'hA: return signed_ge;
            4'hB: return !signed_ge;
            4'hC: return signed_ge && !z;
            4'hD: return !(signed_ge && !z);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge reset) m_flags = RESET_FLAGS;

    always @(posedge clk) begin
        if (reset) begin
            m_flags = RESET_FLAGS;
        end else if (exp_cond(bus.Cond, m_flags)) begin
            if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic e;
            e = exp_cond(bus.Cond, m_flags);
            check("cyc_flags",    bus.Flags, m_flags);
            check("cyc_condex",   {3'b0, bus.CondEx},   {3'b0, e});
            check("cyc_pcsrc",    {3'b0, bus.PCSrc},    {3'b0, bus.PCS  & e});
            check("cyc_regwrite", {3'b0, bus.RegWrite}, {3'b0, bus.RegW & e});
            check("cyc_memwrite", {3'b0, bus.MemWrite}, {3'b0, bus.MemW & e});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw);
        bus.Cond = c; bus.ALUFlags = alu; bus.FlagW = fw;
        bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [3:0] f);
        apply(C_AL, f, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        apply(C_AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        apply(C_AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        check_en = 1'b1;
        tick(); tick();
        check("reset_flags", bus.Flags, 4'b0000);
        reset = 1'b0;

        // 1: asynchronous reset mid-cycle
        load(4'hF);
        check("pre_reset_flags", bus.Flags, 4'hF);
        reset = 1'b1;
        #1;
        check("async_reset_flags", bus.Flags, 4'b0000);
        apply(C_EQ, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reset_eq", {3'b0, bus.CondEx}, 4'h0);
        apply(C_AL, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("reset_al_regwrite", {3'b0, bus.RegWrite}, 4'h1);
        tick();
        reset = 1'b0;

        // 2: full NZCV load
        load(4'b0110);
        check("load_flags", bus.Flags, 4'b0110);
        apply(C_EQ, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("load_eq", {3'b0, bus.CondEx}, 4'h1);
        apply(C_CC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("load_cc", {3'b0, bus.CondEx}, 4'h0);
        tick();

        // 3: partial writes
        load(4'hF);
        apply(C_AL, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        check("partial_nz", bus.Flags, 4'b0011);
        apply(C_AL, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        check("partial_cv", bus.Flags, 4'b0000);

        // 4: failed condition suppresses everything
        apply(C_EQ, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
        check("supp_pcsrc",    {3'b0, bus.PCSrc},    4'h0);
        check("supp_regwrite", {3'b0, bus.RegWrite}, 4'h0);
        check("supp_memwrite", {3'b0, bus.MemWrite}, 4'h0);
        tick();
        check("supp_flags", bus.Flags, 4'b0000);

        // 6: same-cycle ordering, no bypass
        apply(C_NE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        check("order_condex_now", {3'b0, bus.CondEx}, 4'h1);
        tick();
        check("order_flags_next", bus.Flags, 4'b0100);
        apply(C_NE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("order_ne_after", {3'b0, bus.CondEx}, 4'h0);
        tick();

        // 5: spot checks on signed/unsigned compares
        load(4'b1001);
        apply(C_GE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("spot_ge_1001", {3'b0, bus.CondEx}, 4'h1);
        apply(C_LT, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("spot_lt_1001", {3'b0, bus.CondEx}, 4'h0);
        tick();
        load(4'b0100);
        apply(C_GT, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("spot_gt_0100", {3'b0, bus.CondEx}, 4'h0);
        apply(C_LE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("spot_le_0100", {3'b0, bus.CondEx}, 4'h1);
        tick();
        load(4'b0010);
        apply(C_HI, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("spot_hi_0010", {3'b0, bus.CondEx}, 4'h1);
        tick();

        // 5: full sweep of 16 flag values x 16 conditions
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int c = 0; c < 16; c++) begin
                apply(4'(c), 4'($urandom_range(0, 15)), 2'b00,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
                check("sweep_condex", {3'b0, bus.CondEx}, {3'b0, exp_cond(4'(c), 4'(f))});
                if (c == 15) check("sweep_nv", {3'b0, bus.CondEx}, 4'h0);
                tick();
            end
        end

        // Mixed traffic with random flag writes, checked every cycle.
        for (int i = 0; i < 60; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        // ---------------- report ----------------
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
